// File: rtl/rps_match_controller.sv
// Match controller for the stone/paper/scissors referee.
// Drives start/moves, captures results and keeps a best-of-N score.
module rps_match_controller #(
  parameter int         WIN_TARGET  = 2,
  parameter int         MAX_ROUNDS  = 9,
  parameter int         TIMEOUT_CYC = 15,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       match_start,
  input  logic [1:0] p1_move_in,
  input  logic       p1_valid,
  input  logic       p2_auto,
  input  logic [1:0] p2_move_in,
  output logic       ref_start,
  output logic [1:0] ref_p1_move,
  output logic [1:0] ref_p2_move,
  input  logic [1:0] ref_winner,
  input  logic [2:0] ref_state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] round_cnt,
  output logic       busy,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] REF_IDLE   = 3'b000;
  localparam logic [2:0] REF_RESULT = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_ARM,
    S_WAIT_RESULT,
    S_WAIT_IDLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_lfsr;
  logic [TW-1:0] r_tmo;
  logic          r_ref_start;
  logic [1:0]    r_p1_move;
  logic [1:0]    r_p2_move;
  logic [3:0]    r_p1_score;
  logic [3:0]    r_p2_score;
  logic [3:0]    r_round_cnt;
  logic [1:0]    r_winner;
  logic          r_error;

  logic       w_start;
  logic       w_accept;
  logic       w_capture;
  logic       w_timeout;
  logic       w_finish;
  logic       w_tmo_hit;
  logic       w_end;
  logic [1:0] w_win;
  logic [1:0] w_auto;
  logic       w_fb;

  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // Fold the unused code 11 back onto stone/paper.
  assign w_auto = (r_lfsr[1:0] == 2'b11) ? {1'b0, r_lfsr[2]}
                                         : r_lfsr[1:0];

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_end = (r_p1_score == 4'(WIN_TARGET))
         || (r_p2_score == 4'(WIN_TARGET))
         || (r_round_cnt == 4'(MAX_ROUNDS));
    w_win = 2'b00;
    if (r_p1_score == 4'(WIN_TARGET))
      w_win = 2'b01;
    else if (r_p2_score == 4'(WIN_TARGET))
      w_win = 2'b10;
    else if (r_p1_score > r_p2_score)
      w_win = 2'b01;
    else if (r_p2_score > r_p1_score)
      w_win = 2'b10;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (match_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT_MOVE;
        end
      end
      S_WAIT_MOVE: begin
        if (p1_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: w_state_nxt = S_WAIT_RESULT;
      S_WAIT_RESULT: begin
        if (ref_state == REF_RESULT) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WAIT_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ERROR;
        end
      end
      S_WAIT_IDLE: begin
        if (ref_state == REF_IDLE) begin
          if (w_end) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT_MOVE;
          end
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ERROR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr      <= LFSR_SEED;
      r_tmo       <= '0;
      r_ref_start <= 1'b0;
      r_p1_move   <= 2'b00;
      r_p2_move   <= 2'b00;
      r_p1_score  <= 4'd0;
      r_p2_score  <= 4'd0;
      r_round_cnt <= 4'd0;
      r_winner    <= 2'b00;
      r_error     <= 1'b0;
    end else begin
      r_lfsr <= w_start ? LFSR_SEED : {r_lfsr[6:0], w_fb};
      if (r_state == S_ARM || w_capture)
        r_tmo <= '0;
      else if (r_state == S_WAIT_RESULT
            || r_state == S_WAIT_IDLE)
        r_tmo <= r_tmo + TW'(1);
      if (w_start) begin
        r_p1_score  <= 4'd0;
        r_p2_score  <= 4'd0;
        r_round_cnt <= 4'd0;
        r_winner    <= 2'b00;
        r_error     <= 1'b0;
      end
      if (w_accept) begin
        r_p1_move   <= p1_move_in;
        r_p2_move   <= p2_auto ? w_auto : p2_move_in;
        r_ref_start <= 1'b1;
      end
      if (w_capture) begin
        r_ref_start <= 1'b0;
        if (r_round_cnt != 4'(MAX_ROUNDS))
          r_round_cnt <= r_round_cnt + 4'd1;
        if (ref_winner == 2'b01 && r_p1_score != 4'hF)
          r_p1_score <= r_p1_score + 4'd1;
        if (ref_winner == 2'b10 && r_p2_score != 4'hF)
          r_p2_score <= r_p2_score + 4'd1;
      end
      if (w_timeout) begin
        r_error     <= 1'b1;
        r_ref_start <= 1'b0;
      end
      if (w_finish)
        r_winner <= w_win;
    end
  end

  assign ref_start    = r_ref_start;
  assign ref_p1_move  = r_p1_move;
  assign ref_p2_move  = r_p2_move;
  assign p1_score     = r_p1_score;
  assign p2_score     = r_p2_score;
  assign round_cnt    = r_round_cnt;
  assign match_winner = r_winner;
  assign error        = r_error;
  assign match_done   = (r_state == S_DONE);
  assign busy         = !(r_state == S_IDLE
                       || r_state == S_DONE
                       || r_state == S_ERROR);

endmodule
